// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU controller driving the HI/LO write port.
// Division is a 32-step restoring sequencer; multiplication is a counted multicycle path.
`default_nettype none

module muldiv_sequencer #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [4:0] MUL_INIT = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_INIT = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        mul_signed_q, mul_signed_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Product of the sign- or zero-extended operands; modulo 2^64 this is the exact result.
  logic [63:0] w_ext_a, w_ext_b, w_prod;
  assign w_ext_a = {{32{mul_signed_q & a_q[31]}}, a_q};
  assign w_ext_b = {{32{mul_signed_q & b_q[31]}}, b_q};
  assign w_prod  = w_ext_a * w_ext_b;

  // One restoring step: a_q shifts dividend bits out of its MSB and quotient bits into its LSB.
  logic [32:0] w_rem_sh, w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_nx, w_quo_nx, w_quo_fix, w_rem_fix;
  assign w_rem_sh  = {rem_q, a_q[31]};
  assign w_diff    = w_rem_sh - {1'b0, b_q};
  assign w_qbit    = ~w_diff[32];
  assign w_rem_nx  = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
  assign w_quo_nx  = {a_q[30:0], w_qbit};
  assign w_quo_fix = (sa_q ^ sb_q) ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = sa_q ? -w_rem_nx : w_rem_nx;

  logic w_neg_a, w_neg_b;
  assign w_neg_a = op[0] & src_a[31];
  assign w_neg_b = op[0] & src_b[31];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_signed_d = mul_signed_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          rem_d = 32'd0;
          if (!op[1]) begin
            state_d      = S_MUL;
            cnt_d        = MUL_INIT;
            mul_signed_d = op[0];
            sa_d         = 1'b0;
            sb_d         = 1'b0;
            a_d          = src_a;
            b_d          = src_b;
          end else begin
            state_d      = S_DIV;
            cnt_d        = DIV_INIT;
            mul_signed_d = 1'b0;
            sa_d         = w_neg_a;
            sb_d         = w_neg_b;
            a_d          = w_neg_a ? -src_a : src_a;
            b_d          = w_neg_b ? -src_b : src_b;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = w_prod;
          state_d      = S_FIN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          a_d   = w_quo_nx;
          rem_d = w_rem_nx;
          if (cnt_q == 5'd0) begin
            lo_d    = w_quo_fix;
            hi_d    = w_rem_fix;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      mul_signed_q <= 1'b0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rem_q        <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_signed_q <= mul_signed_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign done = (state_q == S_FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (MUL_CYCLES = 4).
`default_nettype none

module tb_muldiv_sequencer;

  localparam int MUL_CYC = 4;
  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_sequencer #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial forever #5 clk = ~clk;

  // Presents start for one cycle, scrambles operands afterwards, and returns in the
  // done cycle (cycle 1 = first cycle after the accepting edge); done_cycle = -1 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output int done_cycle);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = ~o; src_a = 32'hA5A5_A5A5; src_b = 32'h5A5A_5A5A;
    busy_cnt = 0;
    done_cycle = -1;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        done_cycle = k;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int bc, dc;
    run_op(o, a, b, bc, dc);
    vectors++; if (dc !== MUL_CYC + 1) begin miscompares++; $display("FAIL %s_done_cycle got %0d want %0d", name, dc, MUL_CYC + 1); end
    vectors++; if (bc !== MUL_CYC) begin miscompares++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, MUL_CYC); end
    vectors++; if (hi !== ehi) begin miscompares++; $display("FAIL %s_hi got %h want %h", name, hi, ehi); end
    vectors++; if (lo !== elo) begin miscompares++; $display("FAIL %s_lo got %h want %h", name, lo, elo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL %s_after_done got done=%0b busy=%0b want 0 0", name, done, busy); end
  endtask

  task automatic test_div(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int bc, dc;
    run_op(o, a, b, bc, dc);
    vectors++; if (dc !== 33) begin miscompares++; $display("FAIL %s_done_cycle got %0d want 33", name, dc); end
    vectors++; if (bc !== 32) begin miscompares++; $display("FAIL %s_busy_cycles got %0d want 32", name, bc); end
    vectors++; if (hi !== ehi) begin miscompares++; $display("FAIL %s_hi got %h want %h", name, hi, ehi); end
    vectors++; if (lo !== elo) begin miscompares++; $display("FAIL %s_lo got %h want %h", name, lo, elo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s_done_width got %0b want 0", name, done); end
  endtask

  task automatic test_flush();
    int seen_done = 0;
    test_div("preload", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy_before got %0b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy_after got %0b want 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL flush_no_done got %0d done cycles want 0", seen_done); end
    vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL flush_hi got %h want 12345678", hi); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL flush_lo got %h want ffffffff", lo); end
  endtask

  task automatic test_start_while_busy();
    int dc = -1;
    int bc = 0;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) begin start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5; end
      if (k == 6) start = 1'b0;
      if (done) begin dc = k; break; end
      if (busy) bc++;
      @(negedge clk);
    end
    vectors++; if (dc !== 33) begin miscompares++; $display("FAIL busy_start_done_cycle got %0d want 33", dc); end
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL busy_start_result got hi=%h lo=%h want 2 e", hi, lo); end
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fin_start_dropped got busy=%0b want 0", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL fin_start_idle got busy=%0b done=%0b want 0 0", busy, done); end
  endtask

  task automatic test_start_flush_idle();
    int act = 0;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy || done) act++;
      @(negedge clk);
    end
    vectors++; if (act !== 0) begin miscompares++; $display("FAIL start_flush_idle got %0d active cycles want 0", act); end
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'hFFFF_0000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ctl got busy=%0b done=%0b want 0 0", busy, done); end
    vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL mid_reset_hilo got hi=%h lo=%h want 0 0", hi, lo); end
    @(negedge clk);
    resetn = 1'b1;
    run_op(OP_DIVU, 32'd9, 32'd3, bc, dc);
    vectors++; if (dc !== 33) begin miscompares++; $display("FAIL post_reset_done_cycle got %0d want 33", dc); end
    vectors++; if (lo !== 32'd3 || hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_result got hi=%h lo=%h want 0 3", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mul("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_mul("mult_neg1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    test_mul("mult_mixed", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    test_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    test_div("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    test_div("div_neg_by0", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'h0000_0001);
    test_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    test_flush();
    test_start_while_busy();
    test_start_flush_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
